// File: rtl/fmul_arb_if.sv
// Bundles the two requester channels, the multiplier handshake and the result
// channel of the fmul_arb multiplier front-end.
interface fmul_arb_if;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_x;
  logic [31:0] a_y;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_x;
  logic [31:0] b_y;
  logic        mul_req;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic [31:0] mul_rslt;
  logic [4:0]  mul_flag;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_rslt;
  logic [4:0]  o_flag;
  logic        o_src;

  modport slave (
    input  a_valid, a_x, a_y, b_valid, b_x, b_y, mul_rslt, mul_flag, o_ready,
    output a_ready, b_ready, mul_req, mul_x, mul_y, o_valid, o_rslt, o_flag, o_src
  );

  modport master (
    output a_valid, a_x, a_y, b_valid, b_x, b_y, mul_rslt, mul_flag, o_ready,
    input  a_ready, b_ready, mul_req, mul_x, mul_y, o_valid, o_rslt, o_flag, o_src
  );
endinterface

// File: rtl/fmul_arb.sv
// Round-robin front-end sharing one fixed-latency FP multiplier between two
// requesters; one operation in flight, result held until the consumer takes it.
module fmul_arb #(
  parameter int LAT = 6
) (
  input  logic        clk,
  input  logic        reset,
  fmul_arb_if.slave   bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;   // 1 = B was granted last
  logic        src_q, src_d;
  logic [31:0] mx_q, mx_d;
  logic [31:0] my_q, my_d;
  logic [31:0] rslt_q, rslt_d;
  logic [4:0]  flag_q, flag_d;
  logic        osrc_q, osrc_d;
  logic        gnt_a, gnt_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    src_d   = src_q;
    mx_d    = mx_q;
    my_d    = my_q;
    rslt_d  = rslt_q;
    flag_d  = flag_q;
    osrc_d  = osrc_q;
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    case (state_q)
      IDLE: begin
        // Grants are suppressed while reset is held so no accept is lost to it.
        if (reset) begin
          gnt_a = bus.a_valid & (~bus.b_valid | last_q);
          gnt_b = bus.b_valid & (~bus.a_valid | ~last_q);
        end
        if (gnt_a | gnt_b) begin
          mx_d    = gnt_b ? bus.b_x : bus.a_x;
          my_d    = gnt_b ? bus.b_y : bus.a_y;
          src_d   = gnt_b;
          last_d  = gnt_b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 4'(LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rslt_d  = bus.mul_rslt;
          flag_d  = bus.mul_flag;
          osrc_d  = src_q;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (bus.o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      src_q   <= 1'b0;
      mx_q    <= 32'd0;
      my_q    <= 32'd0;
      rslt_q  <= 32'd0;
      flag_q  <= 5'd0;
      osrc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      src_q   <= src_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      rslt_q  <= rslt_d;
      flag_q  <= flag_d;
      osrc_q  <= osrc_d;
    end
  end

  assign bus.a_ready = gnt_a;
  assign bus.b_ready = gnt_b;
  assign bus.mul_req = (state_q == ISSUE);
  assign bus.mul_x   = mx_q;
  assign bus.mul_y   = my_q;
  assign bus.o_valid = (state_q == HOLD);
  assign bus.o_rslt  = rslt_q;
  assign bus.o_flag  = flag_q;
  assign bus.o_src   = osrc_q;

endmodule

// File: tb/tb_fmul_arb.sv
// Directed bench for fmul_arb with a fixed-latency multiplier stub whose
// result is only meaningful in the cycle LAT after mul_req.
module tb_fmul_arb;
  localparam int LAT = 6;

  logic clk = 1'b0;
  logic reset;
  int   nchk = 0;
  int   nerr = 0;
  logic both_seen = 1'b0;

  fmul_arb_if bus ();
  fmul_arb #(.LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Known products: 1.5*2=3, 2*3=6, 1.5*1.5=2.25, sNaN*1 -> quiet NaN with NV.
  function automatic logic [36:0] fmul_ref(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] k;
    k = {x, y};
    case (k)
      64'h3FC00000_40000000: return {5'h00, 32'h40400000};
      64'h40000000_40400000: return {5'h00, 32'h40C00000};
      64'h3FC00000_3FC00000: return {5'h00, 32'h40100000};
      64'h7F800001_3F800000: return {5'h10, 32'h7FC00001};
      default:               return {5'h1F, 32'hBAD0BAD0};
    endcase
  endfunction

  logic [LAT-1:0] pv = '0;
  logic [36:0]    pr [LAT];

  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], bus.mul_req};
    pr[0] <= fmul_ref(bus.mul_x, bus.mul_y);
    for (int i = 1; i < LAT; i++) pr[i] <= pr[i-1];
  end

  assign bus.mul_rslt = pv[LAT-1] ? pr[LAT-1][31:0]  : 32'hDEADBEEF;
  assign bus.mul_flag = pv[LAT-1] ? pr[LAT-1][36:32] : 5'h0A;

  always @(negedge clk) if (bus.a_ready && bus.b_ready) both_seen = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for an accept, follows the op through mul_req and checks the result.
  task automatic do_op(input logic exp_src, input logic [31:0] exp_x, input logic [31:0] exp_y,
                       input logic [31:0] exp_r, input logic [4:0] exp_f, input logic drop);
    int n;
    n = 0;
    #1;
    while (!(bus.a_ready || bus.b_ready) && n < 40) begin
      step();
      n++;
    end
    if (!(bus.a_ready || bus.b_ready)) begin
      chk("accept_timeout", 1'b0, 1'b1);
      return;
    end
    chk("grantee", bus.b_ready, exp_src);
    step();
    if (drop) begin
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      bus.a_x = 32'h0; bus.a_y = 32'h0;
      bus.b_x = 32'h0; bus.b_y = 32'h0;
      #1;
    end
    chk("mul_req_on", bus.mul_req, 1'b1);
    chk("mul_x", bus.mul_x, exp_x);
    chk("mul_y", bus.mul_y, exp_y);
    step();
    chk("mul_req_off", bus.mul_req, 1'b0);
    n = 2;
    while (!bus.o_valid && n < 40) begin
      step();
      n++;
    end
    chk("o_valid_latency", n, LAT + 2);
    chk("o_rslt", bus.o_rslt, exp_r);
    chk("o_flag", bus.o_flag, exp_f);
    chk("o_src", bus.o_src, exp_src);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.a_valid = 1'b1; bus.a_x = 32'h3FC00000; bus.a_y = 32'h40000000;
    bus.b_valid = 1'b0; bus.b_x = 32'h0; bus.b_y = 32'h0;
    bus.o_ready = 1'b0;
    step();
    step();
    chk("rst_a_ready", bus.a_ready, 1'b0);
    chk("rst_mul_req", bus.mul_req, 1'b0);
    chk("rst_mul_x", bus.mul_x, 32'h0);
    chk("rst_o_valid", bus.o_valid, 1'b0);
    chk("rst_o_rslt", bus.o_rslt, 32'h0);
    chk("rst_o_flag", bus.o_flag, 5'h0);
    chk("rst_o_src", bus.o_src, 1'b0);

    // Tie: both held valid, A first after reset, then alternating.
    reset = 1'b1;
    bus.a_x = 32'h40000000; bus.a_y = 32'h40400000;
    bus.b_x = 32'h3FC00000; bus.b_y = 32'h3FC00000;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    bus.o_ready = 1'b1;
    do_op(1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 5'h00, 1'b0);
    do_op(1'b1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 5'h00, 1'b0);
    do_op(1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 5'h00, 1'b0);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    step();

    // Single op with a one-cycle valid.
    bus.a_x = 32'h3FC00000; bus.a_y = 32'h40000000; bus.a_valid = 1'b1;
    do_op(1'b0, 32'h3FC00000, 32'h40000000, 32'h40400000, 5'h00, 1'b1);
    step();

    // Backpressure with A still requesting.
    bus.o_ready = 1'b0;
    bus.a_x = 32'h40000000; bus.a_y = 32'h40400000; bus.a_valid = 1'b1;
    do_op(1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 5'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_o_valid", bus.o_valid, 1'b1);
      chk("bp_o_rslt", bus.o_rslt, 32'h40C00000);
      chk("bp_o_flag", bus.o_flag, 5'h00);
      chk("bp_a_ready", bus.a_ready, 1'b0);
      chk("bp_mul_req", bus.mul_req, 1'b0);
    end
    bus.o_ready = 1'b1;
    step();
    chk("bp_release_o_valid", bus.o_valid, 1'b0);
    chk("bp_release_a_ready", bus.a_ready, 1'b1);
    do_op(1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 5'h00, 1'b1);
    step();

    // Reset two cycles after mul_req, then an immediate B NaN op.
    bus.a_x = 32'h3FC00000; bus.a_y = 32'h40000000; bus.a_valid = 1'b1;
    #1;
    chk("mw_accept", bus.a_ready, 1'b1);
    step();
    bus.a_valid = 1'b0;
    chk("mw_mul_req", bus.mul_req, 1'b1);
    step();
    step();
    reset = 1'b0;
    step();
    chk("mw_state_mul_req", bus.mul_req, 1'b0);
    chk("mw_mul_x", bus.mul_x, 32'h0);
    chk("mw_mul_y", bus.mul_y, 32'h0);
    chk("mw_o_valid", bus.o_valid, 1'b0);
    chk("mw_o_rslt", bus.o_rslt, 32'h0);
    chk("mw_o_src", bus.o_src, 1'b0);
    reset = 1'b1;
    bus.b_x = 32'h7F800001; bus.b_y = 32'h3F800000; bus.b_valid = 1'b1;
    #1;
    chk("post_rst_accept", bus.b_ready, 1'b1);
    do_op(1'b1, 32'h7F800001, 32'h3F800000, 32'h7FC00001, 5'h10, 1'b1);
    step();
    chk("final_idle", bus.o_valid, 1'b0);

    chk("never_both_ready", both_seen, 1'b0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
